// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and helpers for the 7-segment scan controller.
//   scan_state_t : scan FSM states (S_BLANK = guard phase, S_DRIVE = digit on)
//   SEG7_BLANK   : active-low segment pattern with every segment off
//   lz_mask()    : leading-zero blank mask for a packed hex value
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG7_BLANK      = 7'h7F;
    localparam int         SEG7_MAX_DIGITS = 16;

    // Bit k (k > 0) is set when nibbles k..num_digits-1 are all zero.
    // Digit 0 is never part of the mask so a zero value still shows "0".
    function automatic logic [SEG7_MAX_DIGITS-1:0] lz_mask(
        input logic [4*SEG7_MAX_DIGITS-1:0] value,
        input int                           num_digits
    );
        logic [SEG7_MAX_DIGITS-1:0] mask;
        logic                       upper_zero;
        mask       = '0;
        upper_zero = 1'b1;
        for (int k = SEG7_MAX_DIGITS - 1; k >= 1; k--) begin
            if (k < num_digits) begin
                upper_zero = upper_zero & (value[4*k +: 4] == 4'h0);
                mask[k]    = upper_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
// Combinational hex-to-7-segment decoder, active-low outputs, bit order gfedcba.
//   n_rst  in  1  active-low blank (0 forces all segments off)
//   nibble in  4  hex digit to display
//   seg    out 7  segment drive, active-low
// -----------------------------------------------------------------------------
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic       n_rst,
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG7_BLANK;
        if (n_rst) begin
            case (nibble)
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                4'hF: seg = 7'h0E;
                default: seg = SEG7_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for NUM_DIGITS common-anode 7-segment digits.
// New values arrive over valid/ready and are committed only at a frame wrap so
// a frame never mixes old and new digits.
//   clk      in   1             clock
//   rst      in   1             synchronous reset, active-high
//   i_valid  in   1             new display value offered
//   o_ready  out  1             a value can be accepted (no pending value)
//   i_value  in   4*NUM_DIGITS  hex nibbles, nibble k -> digit k (digit 0 = LS)
//   i_dig_en in   NUM_DIGITS    per-digit enable, 0 keeps the digit dark
//   o_seg    out  7             segments, active-low (7'h7F = blank)
//   o_dig_n  out  NUM_DIGITS    anode selects, active-low, one-hot-or-none
//   o_frame  out  1             one-cycle pulse after each frame wrap
// Build option: define SEG7_LZB_EN to enable leading-zero blanking.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dig_en,
    output logic [6:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_dig_n,
    output logic                    o_frame
);

    localparam int CNT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // With no guard phase the blank state is never visited, so the scan
    // starts (and keeps) driving straight away.
    localparam scan_state_t POST_DRIVE = (GUARD_CYC > 0) ? S_BLANK : S_DRIVE;

    scan_state_t            state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [VAL_W-1:0]       active_reg;
    logic [VAL_W-1:0]       pending_reg;
    logic                   pending_valid_reg;
    logic [6:0]             seg_reg, seg_next;
    logic [NUM_DIGITS-1:0]  dig_n_reg, dig_n_next;
    logic                   frame_reg;
    logic                   wrap;
    logic                   xfer;

    logic [3:0]             nibbles [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  dig_sel;
    logic [NUM_DIGITS-1:0]  blank_mask;
    logic [3:0]             nibble_cur;
    logic                   show;
    logic [6:0]             dec_seg;

    // Per-digit nibble slices and one-hot decode of the scan index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibbles[gi] = active_reg[4*gi +: 4];
            assign dig_sel[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

`ifdef SEG7_LZB_EN
    logic [4*SEG7_MAX_DIGITS-1:0] active_ext;
    logic [SEG7_MAX_DIGITS-1:0]   lz_full;
    assign active_ext = (4*SEG7_MAX_DIGITS)'(active_reg);
    assign lz_full    = lz_mask(active_ext, NUM_DIGITS);
    assign blank_mask = lz_full[NUM_DIGITS-1:0];
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        nibble_cur = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_sel[k]) nibble_cur = nibble_cur | nibbles[k];
        end
    end

    seg7_decoder u_decoder (
        .n_rst  (1'b1),
        .nibble (nibble_cur),
        .seg    (dec_seg)
    );

    // Scan sequencing: guard phase, then drive phase, per digit.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        wrap       = 1'b0;
        case (state_reg)
            S_BLANK: begin
                if (cnt_reg == GUARD_LAST) begin
                    state_next = S_DRIVE;
                    cnt_next   = '0;
                end
            end
            default: begin
                if (cnt_reg == DRIVE_LAST) begin
                    state_next = POST_DRIVE;
                    cnt_next   = '0;
                    if (idx_reg == IDX_LAST) begin
                        idx_next = '0;
                        wrap     = 1'b1;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        show       = (state_reg == S_DRIVE) && |(i_dig_en & dig_sel) && !(|(blank_mask & dig_sel));
        dig_n_next = show ? ~dig_sel : '1;
        seg_next   = show ? dec_seg : SEG7_BLANK;
    end

    assign xfer = i_valid & ~pending_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= (GUARD_CYC > 0) ? S_BLANK : S_DRIVE;
            cnt_reg           <= '0;
            idx_reg           <= '0;
            active_reg        <= '0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            seg_reg           <= SEG7_BLANK;
            dig_n_reg         <= '1;
            frame_reg         <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            seg_reg   <= seg_next;
            dig_n_reg <= dig_n_next;
            frame_reg <= wrap;
            // Commit uses the pending flag from before this edge; a transfer
            // landing on the wrap cycle waits for the following wrap.
            if (wrap && pending_valid_reg) begin
                active_reg <= pending_reg;
            end
            if (xfer) begin
                pending_reg       <= i_value;
                pending_valid_reg <= 1'b1;
            end else if (wrap) begin
                pending_valid_reg <= 1'b0;
            end
        end
    end

    assign o_ready = ~pending_valid_reg;
    assign o_seg   = seg_reg;
    assign o_dig_n = dig_n_reg;
    assign o_frame = frame_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Directed plus randomized bench for seg7_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4,
// GUARD_CYC=1). A frame-position reference model predicts every output cycle.
// Honours SEG7_LZB_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int GC    = 1;
    localparam int SLOT  = SD + GC;
    localparam int FRAME = ND * SLOT;

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_value;
    logic [3:0]  i_dig_en;
    logic [6:0]  o_seg;
    logic [3:0]  o_dig_n;
    logic        o_frame;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .GUARD_CYC  (GC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_value  (i_value),
        .i_dig_en (i_dig_en),
        .o_seg    (o_seg),
        .o_dig_n  (o_dig_n),
        .o_frame  (o_frame)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state
    int          m_t = 0;          // cycles since reset release, at next edge
    logic [15:0] m_active = '0;
    logic [15:0] m_pend_val = '0;
    bit          m_pending = 1'b0;
    bit          m_xfer = 1'b0;
    logic [6:0]  e_seg = 7'h7F;
    logic [3:0]  e_dig_n = 4'hF;
    bit          e_frame = 1'b0;
    bit          e_ready = 1'b1;

    int n_edges = 0;
    int last_frame_edge = -1;
    int frame_period = 0;

    function automatic logic [6:0] ref_dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic bit ref_blanked(input logic [15:0] v, input int d);
        return LZB && (d > 0) && ((v >> (4 * d)) == 16'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n_edges);
        end
    endtask

    // Advance the model across one clock edge using the inputs the DUT sees.
    task automatic model_step();
        int slot, d;
        bit lit, pend_pre;
        m_xfer = 1'b0;
        if (rst) begin
            m_t = 0; m_active = '0; m_pending = 1'b0; m_pend_val = '0;
            e_seg = 7'h7F; e_dig_n = 4'hF; e_frame = 1'b0; e_ready = 1'b1;
        end else begin
            slot    = m_t % FRAME;
            d       = slot / SLOT;
            lit     = ((slot % SLOT) >= GC) && i_dig_en[d] && !ref_blanked(m_active, d);
            e_dig_n = lit ? 4'(~(4'b0001 << d)) : 4'hF;
            e_seg   = lit ? ref_dec(m_active[4*d +: 4]) : 7'h7F;
            e_frame = (slot == FRAME - 1);
            pend_pre = m_pending;
            if (e_frame && pend_pre) begin
                m_active  = m_pend_val;
                m_pending = 1'b0;
                $display("commit edge=%0d value=%h", n_edges, m_active);
            end
            if (i_valid && !pend_pre) begin
                m_pending  = 1'b1;
                m_pend_val = i_value;
                m_xfer     = 1'b1;
                $display("xfer   edge=%0d value=%h", n_edges, i_value);
            end
            e_ready = !m_pending;
            m_t++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("o_seg",   32'(o_seg),   32'(e_seg));
        chk("o_dig_n", 32'(o_dig_n), 32'(e_dig_n));
        chk("o_frame", 32'(o_frame), 32'(e_frame));
        chk("o_ready", 32'(o_ready), 32'(e_ready));
        if (o_frame) begin
            if (last_frame_edge >= 0) frame_period = n_edges - last_frame_edge;
            last_frame_edge = n_edges;
        end
        n_edges++;
    endtask

    task automatic send(input logic [15:0] v);
        i_valid = 1'b1;
        i_value = v;
        for (int k = 0; k < 4 * FRAME; k++) begin
            tick();
            if (m_xfer) break;
        end
        chk("send_accepted", 32'(m_xfer), 32'd1);
        i_valid = 1'b0;
    endtask

    task automatic wait_active(input logic [15:0] v);
        for (int k = 0; k < 4 * FRAME; k++) begin
            if (m_active == v && !m_pending) break;
            tick();
        end
        chk("commit_wait", 32'(m_active), 32'(v));
    endtask

    task automatic wait_slot(input int s);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if ((m_t % FRAME) == s) break;
            tick();
        end
    endtask

    // Over one full frame, count cycles showing (dn, sg) and collect lit anodes.
    task automatic measure(input logic [3:0] dn, input logic [6:0] sg,
                           output int hits, output logic [3:0] lit_mask);
        hits = 0;
        lit_mask = 4'h0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (o_dig_n == dn && o_seg == sg) hits++;
            lit_mask = lit_mask | ~o_dig_n;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        logic [3:0] lm;

        // 1. reset
        rst = 1'b1; i_valid = 1'b0; i_value = '0; i_dig_en = 4'hF;
        repeat (3) tick();
        rst = 1'b0;

        // 2. load 1234, check digit slots and frame period
        send(16'h1234);
        wait_active(16'h1234);
        measure(4'b1110, 7'h19, h, lm); chk("d0_show_4", 32'(h), 32'd4);
        measure(4'b1101, 7'h30, h, lm); chk("d1_show_3", 32'(h), 32'd4);
        measure(4'b1011, 7'h24, h, lm); chk("d2_show_2", 32'(h), 32'd4);
        measure(4'b0111, 7'h79, h, lm); chk("d3_show_1", 32'(h), 32'd4);
        chk("frame_period", 32'(frame_period), 32'(FRAME));

        // 3. back-to-back values with valid held
        send(16'hAAAA);
        send(16'hBBBB);
        wait_active(16'hBBBB);
        measure(4'b1110, 7'h03, h, lm); chk("bbbb_d0", 32'(h), 32'd4);

        // 4. digit enables
        i_dig_en = 4'b0101;
        send(16'h8888);
        wait_active(16'h8888);
        measure(4'b1110, 7'h00, h, lm); chk("en_d0_slot", 32'(h), 32'd4);
        chk("en_dark_1_3", 32'(lm & 4'b1010), 32'd0);
        measure(4'b1011, 7'h00, h, lm); chk("en_d2_slot", 32'(h), 32'd4);

        // 5. leading zeros
        i_dig_en = 4'hF;
        send(16'h0070);
        wait_active(16'h0070);
        measure(4'b1101, 7'h78, h, lm); chk("lz_d1", 32'(h), 32'd4);
        chk("lz_upper_lit", 32'(lm[3:2]), LZB ? 32'd0 : 32'd3);
        measure(4'b1110, 7'h40, h, lm); chk("lz_d0", 32'(h), 32'd4);
        measure(4'b1011, 7'h40, h, lm); chk("lz_d2", 32'(h), LZB ? 32'd0 : 32'd4);

        // 6. reset during digit 2 drive with a value pending
        wait_slot(2);
        send(16'h5555);
        wait_slot(2 * SLOT + 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_ready", 32'(o_ready), 32'd1);
        chk("rst_mid_dig_n", 32'(o_dig_n), 32'hF);
        measure(4'b1110, 7'h40, h, lm); chk("rst_active_zero", 32'(h), 32'd4);
        measure(4'b1110, 7'h12, h, lm); chk("rst_pending_lost", 32'(h), 32'd0);

        // 7. randomized traffic
        for (int i = 0; i < 800; i++) begin
            i_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                i_value = 16'($urandom) >> (4 * $urandom_range(0, 3));
            if ($urandom_range(0, 50) == 0) i_dig_en = 4'($urandom);
            rst = ($urandom_range(0, 300) == 0);
            tick();
        end
        rst = 1'b0;
        i_valid = 1'b0;
        repeat (FRAME) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
